canonical_code_builder: RTL and testbench

CANONICAL_CODE_BUILDER -- requirements
Module: canonical_code_builder

---
 rtl/canonical_code_builder.sv | 124 ++++++++++++
 tb/tb_canonical_code_builder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/canonical_code_builder.sv
// canonical_code_builder: builds a canonical (DEFLATE-style) Huffman code table from per-symbol code lengths.
// Counts lengths, derives the first code of each length, then rewrites every symbol with its code.
module canonical_code_builder #(
   parameter int MAX_SYMBOLS = 286,
   parameter int MAX_BITS    = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [8:0]          num_symbols,
   output logic [8:0]          len_rd_addr,
   input  logic [3:0]          len_rd_data,
   output logic                code_wr_en,
   output logic [8:0]          code_wr_addr,
   output logic [MAX_BITS-1:0] code_wr_code,
   output logic [3:0]          code_wr_len,
   output logic                busy,
   output logic                done,
   output logic                error
);
   typedef enum logic [2:0] {IDLE, CLEAR, COUNT, NEXTCODE, ASSIGN, DONE} state_t;
   state_t      state_q, state_d;
   logic [8:0]  n_q, n_d, idx_q, idx_d, rd_addr_q, rd_addr_d;
   logic [3:0]  b_q, b_d;
   logic [16:0] code_q, code_d, nc;
   logic [8:0]  bl_count_q [MAX_BITS+1];
   logic [8:0]  bl_count_d [MAX_BITS+1];
   logic [16:0] next_code_q [MAX_BITS+1];
   logic [16:0] next_code_d [MAX_BITS+1];
   logic        error_q, error_d, last, wr;

   assign last = idx_q == n_q;
   // Read data for address idx_q-1 arrives while idx_q is presented, so work lags the address by one cycle.
   assign wr           = state_q == ASSIGN && idx_q != '0;
   assign code_wr_en   = wr;
   assign code_wr_addr = wr ? idx_q - 9'd1 : '0;
   assign code_wr_len  = wr ? len_rd_data : '0;
   assign code_wr_code = (wr && len_rd_data != '0) ? next_code_q[len_rd_data][MAX_BITS-1:0] : '0;
   assign len_rd_addr  = rd_addr_q;
   assign busy         = state_q != IDLE;
   assign done         = state_q == DONE;
   assign error        = error_q;

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      idx_d       = idx_q;
      rd_addr_d   = rd_addr_q;
      b_d         = b_q;
      code_d      = code_q;
      bl_count_d  = bl_count_q;
      next_code_d = next_code_q;
      error_d     = error_q;
      nc          = '0;
      case (state_q)
         IDLE: if (start) begin
            n_d = num_symbols;
            if (num_symbols == '0 || 32'(num_symbols) > MAX_SYMBOLS) begin
               error_d = 1'b1;
               state_d = DONE;
            end else state_d = CLEAR;
         end
         CLEAR: begin
            bl_count_d  = '{default: '0};
            next_code_d = '{default: '0};
            error_d     = 1'b0;
            code_d      = '0;
            idx_d       = '0;
            rd_addr_d   = '0;
            state_d     = COUNT;
         end
         COUNT: begin
            idx_d     = idx_q + 9'd1;
            rd_addr_d = (idx_q + 9'd1 < n_q) ? idx_q + 9'd1 : '0;
            if (idx_q != '0) bl_count_d[len_rd_data] = bl_count_q[len_rd_data] + 9'd1;
            if (last) begin
               bl_count_d[0] = '0;
               b_d           = 4'd1;
               idx_d         = '0;
               state_d       = NEXTCODE;
            end
         end
         NEXTCODE: begin
            nc              = (code_q + 17'(bl_count_q[b_q - 4'd1])) << 1;
            code_d          = nc;
            next_code_d[b_q] = nc;
            if (nc + 17'(bl_count_q[b_q]) > (17'd1 << b_q)) error_d = 1'b1;
            b_d = b_q + 4'd1;
            if (b_q == 4'(MAX_BITS)) state_d = error_d ? DONE : ASSIGN;
         end
         ASSIGN: begin
            idx_d     = idx_q + 9'd1;
            rd_addr_d = (idx_q + 9'd1 < n_q) ? idx_q + 9'd1 : '0;
            if (wr && len_rd_data != '0) next_code_d[len_rd_data] = next_code_q[len_rd_data] + 17'd1;
            if (last) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q     <= IDLE;
         n_q         <= '0;
         idx_q       <= '0;
         rd_addr_q   <= '0;
         b_q         <= '0;
         code_q      <= '0;
         bl_count_q  <= '{default: '0};
         next_code_q <= '{default: '0};
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         rd_addr_q   <= rd_addr_d;
         b_q         <= b_d;
         code_q      <= code_d;
         bl_count_q  <= bl_count_d;
         next_code_q <= next_code_d;
         error_q     <= error_d;
      end
endmodule

// File: tb/tb_canonical_code_builder.sv
// tb_canonical_code_builder: scoreboard bench; a length-sorted canonical-code model predicts every write and result.
module tb_canonical_code_builder;
   typedef struct {int addr; int code; int len;} wr_t;
   typedef struct {bit err; bit chk; int lat; int start_cyc;} res_t;

   logic        clk = 0, reset = 0, start = 0;
   logic [8:0]  num_symbols = '0, len_rd_addr, code_wr_addr;
   logic [3:0]  len_rd_data, code_wr_len;
   logic [14:0] code_wr_code;
   logic        code_wr_en, busy, done, error;
   logic [3:0]  lenmem [512];
   int          cyc = 0, checks = 0, errors = 0;
   bit          exp_err;
   wr_t         wq[$];
   res_t        rq[$];
   wr_t         mw;
   res_t        mr;

   canonical_code_builder dut (
      .clk(clk), .reset(reset), .start(start), .num_symbols(num_symbols),
      .len_rd_addr(len_rd_addr), .len_rd_data(len_rd_data),
      .code_wr_en(code_wr_en), .code_wr_addr(code_wr_addr), .code_wr_code(code_wr_code),
      .code_wr_len(code_wr_len), .busy(busy), .done(done), .error(error));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      len_rd_data <= lenmem[len_rd_addr];
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (reset) begin
      if (code_wr_en) begin
         if (wq.size() == 0) chk("unexpected_write", 1, 0);
         else begin
            mw = wq.pop_front();
            chk("wr_addr", int'(code_wr_addr), mw.addr);
            chk("wr_code", int'(code_wr_code), mw.code);
            chk("wr_len", int'(code_wr_len), mw.len);
         end
      end else chk("idle_wr_zero", int'(|{code_wr_addr, code_wr_code, code_wr_len}), 0);
      if (done) begin
         if (rq.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            mr = rq.pop_front();
            chk("done_error", int'(error), int'(mr.err));
            chk("busy_at_done", int'(busy), 1);
            chk("writes_left_at_done", wq.size(), 0);
            if (mr.chk) chk("done_latency", cyc - mr.start_cyc + 1, mr.lat);
         end
      end
   end

   task automatic issue(int n);
      int kraft = 0, code = 0;
      int codes [512];
      res_t r;
      for (int s = 0; s < n && s < 512; s++) if (lenmem[s] != 0) kraft += 1 << (15 - lenmem[s]);
      r.err = (n == 0) || (n > 286) || (kraft > 32768);
      if (!r.err) begin
         for (int l = 1; l <= 15; l++) begin
            for (int s = 0; s < n; s++) if (int'(lenmem[s]) == l) codes[s] = code++;
            code = code << 1;
         end
         for (int s = 0; s < n; s++) wq.push_back('{s, lenmem[s] != 0 ? codes[s] : 0, int'(lenmem[s])});
      end
      r.chk = !r.err;
      r.lat = 2 * n + 19;
      @(negedge clk);
      start       = 1;
      num_symbols = 9'(n);
      r.start_cyc = cyc + 1;
      rq.push_back(r);
      exp_err = r.err;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (rq.size() != 0 && t < 1500) begin
         @(negedge clk);
         t++;
      end
      if (rq.size() != 0) begin
         chk("done_timeout", 0, 1);
         rq.delete();
         wq.delete();
      end
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("error_held", int'(error), int'(exp_err));
   endtask

   task automatic set_ex40();
      foreach (lenmem[i]) lenmem[i] = 0;
      lenmem[0] = 3; lenmem[1] = 3; lenmem[2] = 3; lenmem[3] = 3;
      lenmem[4] = 3; lenmem[5] = 2; lenmem[6] = 4; lenmem[7] = 4;
   endtask

   task automatic check_reset_outputs(string name);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_done"}, int'(done), 0);
      chk({name, "_error"}, int'(error), 0);
      chk({name, "_wr_en"}, int'(code_wr_en), 0);
      chk({name, "_outs"}, int'(|{len_rd_addr, code_wr_addr, code_wr_code, code_wr_len}), 0);
   endtask

   initial begin
      foreach (lenmem[i]) lenmem[i] = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1;
      set_ex40();
      issue(8);
      wait_done();
      foreach (lenmem[i]) lenmem[i] = i < 144 ? 8 : i < 256 ? 9 : i < 280 ? 7 : 8;
      issue(286);
      wait_done();
      foreach (lenmem[i]) lenmem[i] = 0;
      lenmem[0] = 1;
      issue(30);
      wait_done();
      lenmem[1] = 1; lenmem[2] = 1;
      issue(3);
      wait_done();
      issue(0);
      wait_done();
      issue(300);
      wait_done();
      set_ex40();
      issue(8);
      repeat (3) @(negedge clk);
      start = 1; num_symbols = 9'd0;
      @(negedge clk);
      start = 0;
      wait_done();
      issue(0);
      wait_done();
      issue(8);
      repeat (30) @(negedge clk);
      reset = 0;
      #1 check_reset_outputs("mid_reset");
      wq.delete();
      rq.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs("mid_reset_hold");
      reset = 1;
      repeat (6) @(negedge clk);
      chk("idle_after_abort", int'(busy), 0);
      issue(8);
      wait_done();
      for (int i = 0; i < 24; i++) begin
         int n, v;
         foreach (lenmem[j]) lenmem[j] = 0;
         if (i % 2 == 0) begin
            n = $urandom_range(1, 286);
            for (int s = 0; s < n; s++) lenmem[s] = 4'($urandom_range(0, 15));
         end else begin
            n = $urandom_range(1, 256);
            for (int s = 0; s < n; s++) begin
               v = $urandom_range(7, 15);
               lenmem[s] = v == 7 ? 4'd0 : 4'(v);
            end
         end
         issue(n);
         wait_done();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
